// File: rtl/sync_frame_pkg.sv
// sync_frame_pkg: shared constants and state encoding for the 1010-sync transmitter
package sync_frame_pkg;
  localparam logic [3:0] SYNC_WORD = 4'b1010;
  localparam int SYNC_LEN = 4;
  localparam logic [2:0] STUFF_TRIG = 3'b101;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_STUFF = 3'd3;
  localparam logic [2:0] ST_GAP = 3'd4;
endpackage

// File: rtl/sync_frame_tx_hist.sv
// tx_hist3: history of the last three bits put on the line, flags a pending 101
module tx_hist3
  import sync_frame_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift,
  input  logic din,
  output logic stuff_req
);
  logic [2:0] hist;
  always_ff @(posedge clk) begin
    if (reset) hist <= '0;
    else if (clr || shift) hist <= {clr ? 2'b00 : hist[1:0], din};
  end
  assign stuff_req = hist == STUFF_TRIG;
endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: 1010 preamble + MSB-first payload with bit stuffing and idle gap
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int FW = SYNC_LEN + DATA_W;
  localparam int LW = $clog2(FW + 1);
  localparam int CW = $clog2(GAP_LEN + 1);
  localparam logic [LW-1:0] FRAME_LEFT = LW'(FW - 1);
  localparam logic [LW-1:0] DATA_LEFT = LW'(DATA_W);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN);
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] left, left_n;
  logic [FW-1:0] sr, sr_n, frame;
  logic tx_n, busy_n, done_n, clr, shift, stuff_req;
  assign frame = {SYNC_WORD, data};
  tx_hist3 u_hist (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .shift(shift),
    .din(tx_n),
    .stuff_req(stuff_req)
  );
  // Preamble and payload share one shift register; left counts bits not yet sent,
  // and stuffing is only armed once the preamble is fully out (left <= DATA_W).
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    left_n = left;
    sr_n = sr;
    tx_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    clr = 1'b0;
    shift = 1'b0;
    case (state)
      ST_IDLE:
        if (start && !busy) begin
          state_n = ST_PRE;
          tx_n = frame[FW-1];
          sr_n = frame << 1;
          left_n = FRAME_LEFT;
          busy_n = 1'b1;
          clr = 1'b1;
        end
      ST_PRE, ST_DATA, ST_STUFF:
        if (stuff_req && left <= DATA_LEFT) begin
          state_n = ST_STUFF;
          tx_n = 1'b1;
          shift = 1'b1;
        end else if (left != '0) begin
          state_n = left > DATA_LEFT ? ST_PRE : ST_DATA;
          tx_n = sr[FW-1];
          sr_n = sr << 1;
          left_n = left - 1'b1;
          shift = 1'b1;
        end else begin
          state_n = ST_GAP;
          cnt_n = CW'(1);
        end
      ST_GAP:
        if (cnt != GAP_LAST) cnt_n = cnt + 1'b1;
        else begin
          state_n = ST_IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      default: begin
        state_n = ST_IDLE;
        busy_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      left <= '0;
      sr <= '0;
      tx <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      left <= left_n;
      sr <= sr_n;
      tx <= tx_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule
